ara_perf_csr: RTL and testbench

- APB slave that captures Ara vector-runtime and CVA6 stall measurements and exposes them to software as 32-bit registers.
- Sits downstream of the harness runtime/stall counters. It consumes their buffered 64-bit values on an update strobe.
- It also sources the SW counter-enable that gates those counters.
- Provides atomic 64-bit reads over a 32-bit bus through a hi-word shadow latch.

---
 rtl/ara_perf_csr.sv | 106 ++++++++++
 tb/tb_ara_perf_csr.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ara_perf_csr.sv
// ara_perf_csr: APB register block for Ara runtime / CVA6 stall counters.
// Captures four 64-bit counter snapshots on update_i and exposes them as
// LO/HI 32-bit words. Reading a LO word latches its HI half into a shared
// shadow so that a following HI read is atomic with the LO read.
// Ports:
//   clk_i, rst_ni                        clock, async active-low reset
//   update_i                             strobe: the four 64-bit inputs are new
//   runtime_i, dcache_stall_i,
//   icache_stall_i, sb_full_i            64-bit counter values
//   hw_cnt_en_o                          registered SW counter enable (CTRL[0])
//   psel_i, penable_i, pwrite_i,
//   paddr_i, pwdata_i                    APB request
//   prdata_o, pready_o, pslverr_o        APB response, nonzero only on completion
// Build option: define ARA_PERF_CSR_WAIT_EN to insert one wait cycle into
// every ACCESS phase (three-cycle transfers).
module ara_perf_csr #(
  parameter int AddrDecodeBits = 6,
  parameter int UpdCntWidth    = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        update_i,
  input  logic [63:0] runtime_i,
  input  logic [63:0] dcache_stall_i,
  input  logic [63:0] icache_stall_i,
  input  logic [63:0] sb_full_i,
  output logic        hw_cnt_en_o,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] paddr_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o
);
  localparam int IW = AddrDecodeBits - 2;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;
  state_e                 r_state, w_state_nx;
  logic [63:0]            r_snap [4];
  logic [31:0]            r_shadow;
  logic                   r_valid;
  logic                   r_cnt_en;
  logic [UpdCntWidth-1:0] r_upd_cnt;
  logic [IW-1:0]          w_idx;
  logic [1:0]             w_sel;
  logic                   w_acc, w_done, w_err, w_wr, w_rd_lo, w_clr, w_w1c;
  logic [31:0]            w_rdata;
  logic                   w_unused;
  assign w_unused = ^{paddr_i[31:AddrDecodeBits], pwdata_i[31:2]};
  assign w_idx    = paddr_i[AddrDecodeBits-1:2];
  // Word index 2..9 maps to snapshots 0..3 in LO/HI pairs.
  assign w_sel    = w_idx[2:1] - 2'd1;
  always_comb begin
    w_acc = psel_i & penable_i & (r_state == S_SETUP | r_state == S_ACCESS);
`ifdef ARA_PERF_CSR_WAIT_EN
    // First ACCESS cycle is a wait cycle; completion comes one cycle later.
    w_done = w_acc & (r_state == S_ACCESS);
`else
    w_done = w_acc & (r_state == S_SETUP);
`endif
    w_state_nx = (psel_i & ~penable_i) ? S_SETUP :
                 (w_acc & ~w_done)     ? S_ACCESS : S_IDLE;
    w_err   = (|paddr_i[1:0]) | (w_idx > IW'(9)) | (pwrite_i & (w_idx > IW'(1)));
    w_wr    = w_done & pwrite_i & ~w_err;
    w_rd_lo = w_done & ~pwrite_i & ~w_err & ~w_idx[0] & (w_idx > IW'(1));
    w_clr   = w_wr & (w_idx == IW'(0)) & pwdata_i[1];
    w_w1c   = w_wr & (w_idx == IW'(1)) & pwdata_i[0];
    w_rdata = (w_idx == IW'(0)) ? {31'd0, r_cnt_en} :
              (w_idx == IW'(1)) ? {16'(r_upd_cnt), 15'd0, r_valid} :
              w_idx[0]          ? r_shadow : r_snap[w_sel][31:0];
    pready_o  = w_done;
    pslverr_o = w_done & w_err;
    prdata_o  = (w_done & ~w_err & ~pwrite_i) ? w_rdata : 32'd0;
  end
  assign hw_cnt_en_o = r_cnt_en;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_snap    <= '{default: '0};
      r_shadow  <= '0;
      r_valid   <= 1'b0;
      r_cnt_en  <= 1'b0;
      r_upd_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_wr & (w_idx == IW'(0))) r_cnt_en <= pwdata_i[0];
      // Clear dominates a coincident update; update (set) dominates W1C.
      if (w_clr) begin
        r_snap    <= '{default: '0};
        r_shadow  <= '0;
        r_valid   <= 1'b0;
        r_upd_cnt <= '0;
      end else begin
        if (update_i) begin
          r_snap <= '{runtime_i, dcache_stall_i, icache_stall_i, sb_full_i};
          r_valid <= 1'b1;
          if (~&r_upd_cnt) r_upd_cnt <= r_upd_cnt + UpdCntWidth'(1);
        end else if (w_w1c) begin
          r_valid <= 1'b0;
        end
        if (w_rd_lo) r_shadow <= r_snap[w_sel][63:32];
      end
    end
  end
endmodule

// File: tb/tb_ara_perf_csr.sv
// tb_ara_perf_csr: directed plus randomized checks of ara_perf_csr against a
// register-level model of the CSR map (snapshots, shadow, valid, counter).
module tb_ara_perf_csr;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        update_i = 1'b0;
  logic [63:0] runtime_i = '0, dcache_stall_i = '0, icache_stall_i = '0, sb_full_i = '0;
  logic        hw_cnt_en_o;
  logic        psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
  logic [31:0] paddr_i = '0, pwdata_i = '0;
  logic [31:0] prdata_o;
  logic        pready_o, pslverr_o;
`ifdef ARA_PERF_CSR_WAIT_EN
  localparam int EXP_WAIT = 1;
`else
  localparam int EXP_WAIT = 0;
`endif
  int errors = 0;
  int checks = 0;
  logic [63:0] m_snap [4];
  logic [31:0] m_shadow;
  bit          m_valid, m_en;
  int          m_cnt;
  ara_perf_csr dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .update_i(update_i),
    .runtime_i(runtime_i), .dcache_stall_i(dcache_stall_i),
    .icache_stall_i(icache_stall_i), .sb_full_i(sb_full_i),
    .hw_cnt_en_o(hw_cnt_en_o), .psel_i(psel_i), .penable_i(penable_i),
    .pwrite_i(pwrite_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_snap[i] = '0;
    m_shadow = '0; m_valid = 0; m_en = 0; m_cnt = 0;
  endtask
  task automatic m_update();
    m_snap[0] = runtime_i; m_snap[1] = dcache_stall_i;
    m_snap[2] = icache_stall_i; m_snap[3] = sb_full_i;
    m_valid = 1;
    if (m_cnt < 65535) m_cnt++;
  endtask
  function automatic bit m_err(input bit wr, input logic [31:0] a);
    logic [5:0] o = a[5:0];
    return (a[1:0] != 2'd0) || (o >= 6'h28) || (wr && o >= 6'h08);
  endfunction
  function automatic logic [31:0] m_rdata(input logic [31:0] a);
    logic [5:0] o = a[5:0];
    if (m_err(0, a)) return 32'd0;
    if (o == 6'h00) return {31'd0, m_en};
    if (o == 6'h04) return {m_cnt[15:0], 15'd0, m_valid};
    if (o[2]) return m_shadow;
    return m_snap[(o - 6'h08) >> 3][31:0];
  endfunction
  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     input bit upd, output logic [31:0] rd, output logic err);
    int w = 0;
    @(negedge clk_i);
    psel_i = 1; penable_i = 0; pwrite_i = wr; paddr_i = addr; pwdata_i = wd;
    @(negedge clk_i);
    penable_i = 1;
    #1;
    while (pready_o !== 1'b1 && w < 4) begin
      @(negedge clk_i); #1; w++;
    end
    chk("pready", pready_o, 1);
    chk("wait_cycles", w, EXP_WAIT);
    rd = prdata_o; err = pslverr_o;
    if (upd) update_i = 1;
    @(negedge clk_i);
    psel_i = 0; penable_i = 0; update_i = 0;
  endtask
  task automatic rd_chk(input logic [31:0] addr, input string tag, output logic [31:0] rd);
    logic e;
    logic [31:0] exp_d = m_rdata(addr);
    bit exp_e = m_err(0, addr);
    apb(0, addr, 32'd0, 0, rd, e);
    chk({tag, "_data"}, rd, exp_d);
    chk({tag, "_err"}, e, exp_e);
    if (!exp_e && addr[5:0] >= 6'h08 && !addr[2]) m_shadow = m_snap[(addr[5:0] - 6'h08) >> 3][63:32];
  endtask
  task automatic wr_chk(input logic [31:0] addr, input logic [31:0] d, input bit upd, input string tag);
    logic [31:0] rd;
    logic e;
    bit exp_e = m_err(1, addr);
    bit clr = !exp_e && addr[5:0] == 6'h00 && d[1];
    apb(1, addr, d, upd, rd, e);
    chk({tag, "_err"}, e, exp_e);
    chk({tag, "_rdata"}, rd, 0);
    if (!exp_e && addr[5:0] == 6'h00) m_en = d[0];
    if (!exp_e && addr[5:0] == 6'h04 && d[0] && !upd) m_valid = 0;
    if (clr) begin
      for (int i = 0; i < 4; i++) m_snap[i] = '0;
      m_shadow = '0; m_valid = 0; m_cnt = 0;
    end else if (upd) m_update();
  endtask
  task automatic pulse();
    @(negedge clk_i); update_i = 1;
    @(negedge clk_i); update_i = 0;
    m_update();
  endtask
  task automatic rand_vals();
    runtime_i = {$urandom, $urandom}; dcache_stall_i = {$urandom, $urandom};
    icache_stall_i = {$urandom, $urandom}; sb_full_i = {$urandom, $urandom};
  endtask
  initial begin
    logic [31:0] rd;
    m_reset();
    #2;
    chk("rst_pready", pready_o, 0);
    chk("rst_prdata", prdata_o, 0);
    chk("rst_pslverr", pslverr_o, 0);
    chk("rst_cnt_en", hw_cnt_en_o, 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1;
    rd_chk(32'h00, "rst_ctrl", rd);
    rd_chk(32'h04, "rst_status", rd);
    rd_chk(32'h08, "rst_rt_lo", rd);
    rd_chk(32'h0C, "rst_rt_hi", rd);
    chk("rst_cnt_en2", hw_cnt_en_o, 0);
    wr_chk(32'h00, 32'h1, 0, "ctrl_en");
    chk("cnt_en_after", hw_cnt_en_o, 1);
    rd_chk(32'h00, "ctrl_rd", rd);
    chk("ctrl_val", rd, 32'h1);
    runtime_i = 64'h0000_0012_3456_789A;
    pulse();
    rd_chk(32'h08, "rt_lo", rd);
    chk("rt_lo_val", rd, 32'h3456_789A);
    rd_chk(32'h0C, "rt_hi", rd);
    chk("rt_hi_val", rd, 32'h0000_0012);
    rd_chk(32'h04, "status1", rd);
    chk("status1_val", rd, 32'h0001_0001);
    rd_chk(32'h08, "rt_lo2", rd);
    runtime_i = 64'hFFFF_FFFF_0000_0000;
    pulse();
    rd_chk(32'h0C, "rt_hi_shadow", rd);
    chk("rt_hi_shadow_val", rd, 32'h0000_0012);
    for (int i = 0; i < 150; i++) begin
      int op = $urandom_range(0, 3);
      if (op == 0) begin
        rand_vals(); pulse();
      end else if (op == 3) begin
        if ($urandom_range(0, 1) == 1) rand_vals();
        wr_chk(32'h04 | ($urandom & 32'hFFFF_FFC0), $urandom, 1'($urandom_range(0, 1)), "rnd_w1c");
      end else begin
        logic [31:0] a = ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 9)) << 2);
        rd_chk(a, "rnd_rd", rd);
      end
    end
    rand_vals();
    @(negedge clk_i); update_i = 1;
    repeat (65540) @(negedge clk_i);
    update_i = 0;
    repeat (65540) m_update();
    rd_chk(32'h04, "sat", rd);
    chk("sat_cnt", rd[31:16], 16'hFFFF);
    wr_chk(32'h00, 32'h3, 1, "clr");
    rd_chk(32'h04, "clr_status", rd);
    chk("clr_status_val", rd, 0);
    rd_chk(32'h08, "clr_rt_lo", rd);
    chk("clr_rt_lo_val", rd, 0);
    chk("clr_cnt_en", hw_cnt_en_o, 1);
    rand_vals(); pulse();
    rd_chk(32'h28, "unmapped", rd);
    wr_chk(32'h08, 32'hDEAD_BEEF, 0, "wr_ro");
    rd_chk(32'h0A, "misaligned", rd);
    rd_chk(32'h04, "err_status", rd);
    rd_chk(32'h10, "err_dc_lo", rd);
    rd_chk(32'h14, "err_dc_hi", rd);
    @(negedge clk_i);
    psel_i = 1; penable_i = 0; pwrite_i = 1; paddr_i = 32'h00; pwdata_i = 32'h0;
    @(negedge clk_i); psel_i = 0;
    #1;
    chk("abort_pready", pready_o, 0);
    @(negedge clk_i);
    chk("abort_cnt_en", hw_cnt_en_o, 1);
    rd_chk(32'h00, "abort_ctrl", rd);
    @(negedge clk_i);
    psel_i = 1; penable_i = 0; pwrite_i = 0; paddr_i = 32'h08;
    @(negedge clk_i); penable_i = 1;
    #1; rst_ni = 0; #1;
    chk("arst_pready", pready_o, 0);
    chk("arst_prdata", prdata_o, 0);
    chk("arst_pslverr", pslverr_o, 0);
    chk("arst_cnt_en", hw_cnt_en_o, 0);
    psel_i = 0; penable_i = 0;
    @(negedge clk_i); rst_ni = 1;
    m_reset();
    rd_chk(32'h04, "arst_status", rd);
    rd_chk(32'h08, "arst_rt_lo", rd);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
